ones_run_frame_stats: RTL

//  Downstream consumer of the pipelined longest-ones-run tree. Realigns the word

---
 rtl/ones_run_frame_stats_if.sv | 30 +++
 rtl/ones_run_frame_stats.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ones_run_frame_stats_if.sv
// Sideband, tree-result and frame-result signals between the longest-ones-run
// tree environment (master) and the frame statistics block (slave).
interface ones_run_frame_stats_if #(
  parameter int WORD_SIZE = 256,
  parameter int CNT_W     = 16
);
  localparam int LEN_W = $clog2(WORD_SIZE) + 1;

  logic             in_valid;
  logic             in_last;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] thresh;
  logic             alarm;
  logic             res_valid;
  logic             res_ready;
  logic [LEN_W-1:0] res_max;
  logic [CNT_W-1:0] res_words;
  logic [CNT_W-1:0] res_hits;
  logic             res_overrun;

  modport master (
    output in_valid, in_last, run_len, thresh, res_ready,
    input  alarm, res_valid, res_max, res_words, res_hits, res_overrun
  );

  modport slave (
    input  in_valid, in_last, run_len, thresh, res_ready,
    output alarm, res_valid, res_max, res_words, res_hits, res_overrun
  );
endinterface

// File: rtl/ones_run_frame_stats.sv
// Per-frame statistics behind the pipelined longest-ones-run tree: realigns the
// word sideband to the tree latency, accumulates peak/count/hits, hands one result per frame.
module ones_run_frame_stats #(
  parameter int WORD_SIZE = 256,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ones_run_frame_stats_if.slave bus
);
  localparam int               LAT     = 1 + $clog2(WORD_SIZE / 8);
  localparam int               LEN_W   = $clog2(WORD_SIZE) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ACC_IDLE, ACC_RUN}    acc_st_e;
  typedef enum logic {RES_EMPTY, RES_FULL}  res_st_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] max_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [LAT-1:0]   vld_dly_q;
  logic [LAT-1:0]   lst_dly_q;

  acc_st_e          acc_st_q;
  logic [LEN_W-1:0] acc_max_q;
  logic [CNT_W-1:0] acc_words_q;
  logic [CNT_W-1:0] acc_hits_q;
  logic             alarm_q;

  res_st_e          res_st_q;
  logic [LEN_W-1:0] res_max_q;
  logic [CNT_W-1:0] res_words_q;
  logic [CNT_W-1:0] res_hits_q;
  logic             res_overrun_q;

  logic             d_valid;
  logic             d_last;
  logic             hit;
  logic             frame_end;
  logic [LEN_W-1:0] base_max;
  logic [CNT_W-1:0] base_words;
  logic [CNT_W-1:0] base_hits;
  logic [LEN_W-1:0] acc_max_d;
  logic [CNT_W-1:0] acc_words_d;
  logic [CNT_W-1:0] acc_hits_d;

  // ---- stage 0: sideband delay line, matches the tree latency (no stall) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_dly_q <= '0;
      lst_dly_q <= '0;
    end else begin
      vld_dly_q[0] <= bus.in_valid;
      lst_dly_q[0] <= bus.in_valid & bus.in_last;
      for (int i = 1; i < LAT; i++) begin
        vld_dly_q[i] <= vld_dly_q[i-1];
        lst_dly_q[i] <= lst_dly_q[i-1];
      end
    end
  end

  assign d_valid   = vld_dly_q[LAT-1];
  assign d_last    = lst_dly_q[LAT-1];
  assign hit       = (bus.run_len >= bus.thresh);
  assign frame_end = d_valid & d_last;

  // An idle accumulator contributes nothing, so the first word of a frame starts from zero.
  always_comb begin
    base_max   = '0;
    base_words = '0;
    base_hits  = '0;
    if (acc_st_q == ACC_RUN) begin
      base_max   = acc_max_q;
      base_words = acc_words_q;
      base_hits  = acc_hits_q;
    end
    acc_max_d   = max_len(base_max, bus.run_len);
    acc_words_d = sat_inc(base_words);
    acc_hits_d  = hit ? sat_inc(base_hits) : base_hits;
  end

  // ---- stage 1: frame accumulation and per-word alarm ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_st_q    <= ACC_IDLE;
      acc_max_q   <= '0;
      acc_words_q <= '0;
      acc_hits_q  <= '0;
      alarm_q     <= 1'b0;
    end else begin
      alarm_q <= d_valid & hit;
      if (d_valid) begin
        if (d_last) begin
          acc_st_q    <= ACC_IDLE;
          acc_max_q   <= '0;
          acc_words_q <= '0;
          acc_hits_q  <= '0;
        end else begin
          acc_st_q    <= ACC_RUN;
          acc_max_q   <= acc_max_d;
          acc_words_q <= acc_words_d;
          acc_hits_q  <= acc_hits_d;
        end
      end
    end
  end

  // ---- stage 2: single-entry result holding register with drop-on-full ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_st_q      <= RES_EMPTY;
      res_max_q     <= '0;
      res_words_q   <= '0;
      res_hits_q    <= '0;
      res_overrun_q <= 1'b0;
    end else begin
      case (res_st_q)
        RES_EMPTY: begin
          if (frame_end) begin
            res_st_q    <= RES_FULL;
            res_max_q   <= acc_max_d;
            res_words_q <= acc_words_d;
            res_hits_q  <= acc_hits_d;
          end
        end
        RES_FULL: begin
          if (bus.res_ready) begin
            if (frame_end) begin
              res_max_q   <= acc_max_d;
              res_words_q <= acc_words_d;
              res_hits_q  <= acc_hits_d;
            end else begin
              res_st_q <= RES_EMPTY;
            end
          end else if (frame_end) begin
            res_overrun_q <= 1'b1;
          end
        end
        default: res_st_q <= RES_EMPTY;
      endcase
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.res_valid   = (res_st_q == RES_FULL);
  assign bus.res_max     = res_max_q;
  assign bus.res_words   = res_words_q;
  assign bus.res_hits    = res_hits_q;
  assign bus.res_overrun = res_overrun_q;

endmodule
